// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths and write-back source encoding for the register file controller
package regfile_pkg;
    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 32;
    typedef enum logic {SRC_A, SRC_M} src_e;
endpackage

// File: rtl/regfile_wb_ctrl_rr_arb2.sv
// rr_arb2: two-request round-robin arbiter
// Ports: clk, reset_n (sync, active low), a_req/m_req requests, a_gnt/m_gnt one-hot grants.
// Grants are forced low while reset_n is low; the pointer only moves on contention.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic a_req,
    input  logic m_req,
    output logic a_gnt,
    output logic m_gnt
);
    src_e ptr;

    always_comb begin
        a_gnt = reset_n && a_req && (!m_req || ptr == SRC_A);
        m_gnt = reset_n && m_req && !a_gnt;
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            ptr <= SRC_A;
        else if (a_req && m_req)
            ptr <= a_gnt ? SRC_M : SRC_A;
    end
endmodule

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: write-back port arbiter and busy scoreboard for the 32 x 64 register file
// Ports: a_*/m_* valid/ready write-back sources; issue_* destination reservation;
// R_Addr/S_Addr -> r_busy/s_busy hazard flags; W_En/W_Addr/WR drive the regfile write port.
module regfile_wb_ctrl
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              m_valid,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_data,
    output logic              m_ready,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              issue_ready,
    input  logic [ADDR_W-1:0] R_Addr,
    input  logic [ADDR_W-1:0] S_Addr,
    output logic              r_busy,
    output logic              s_busy,
    output logic              W_En,
    output logic [ADDR_W-1:0] W_Addr,
    output logic [DATA_W-1:0] WR
);
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] set_m;
    logic [NREGS-1:0] clr_m;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .a_req   (a_valid),
        .m_req   (m_valid),
        .a_gnt   (a_ready),
        .m_gnt   (m_ready)
    );

    always_comb begin
        issue_ready = reset_n && issue_valid && !busy[issue_addr];
        r_busy      = busy[R_Addr];
        s_busy      = busy[S_Addr];
        set_m       = issue_ready ? (NREGS'(1) << issue_addr) : '0;
        clr_m       = W_En ? (NREGS'(1) << W_Addr) : '0;
    end

    // Set is applied after clear so a same-cycle reservation of the address being written survives.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            W_En   <= 1'b0;
            W_Addr <= '0;
            WR     <= '0;
            busy   <= '0;
        end else begin
            W_En <= a_ready || m_ready;
            if (a_ready) begin
                W_Addr <= a_addr;
                WR     <= a_data;
            end else if (m_ready) begin
                W_Addr <= m_addr;
                WR     <= m_data;
            end
            busy <= (busy & ~clr_m) | set_m;
        end
    end
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb_regfile_wb_ctrl: directed plus randomized checking of regfile_wb_ctrl against a behavioural model
module tb_regfile_wb_ctrl;
    import regfile_pkg::*;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              a_valid = 1'b0, m_valid = 1'b0, issue_valid = 1'b0;
    logic [ADDR_W-1:0] a_addr = '0, m_addr = '0, issue_addr = '0, R_Addr = '0, S_Addr = '0;
    logic [DATA_W-1:0] a_data = '0, m_data = '0;
    logic              a_ready, m_ready, issue_ready, r_busy, s_busy, W_En;
    logic [ADDR_W-1:0] W_Addr;
    logic [DATA_W-1:0] WR;

    regfile_wb_ctrl dut (
        .clk(clk), .reset_n(reset_n),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .m_valid(m_valid), .m_addr(m_addr), .m_data(m_data), .m_ready(m_ready),
        .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready),
        .R_Addr(R_Addr), .S_Addr(S_Addr), .r_busy(r_busy), .s_busy(s_busy),
        .W_En(W_En), .W_Addr(W_Addr), .WR(WR)
    );

    always #50 clk = ~clk;

    // The register file itself, driven by the DUT's write port.
    logic [DATA_W-1:0] rf_act [NREGS];
    always @(posedge clk) if (W_En === 1'b1) rf_act[W_Addr] <= WR;

    // Reference model: pending-write flags, expected regfile contents, expected write port,
    // and which source should win the next contention.
    bit                busy_m [NREGS];
    logic [DATA_W-1:0] rf_m [NREGS];
    bit                me_en = 0;
    logic [ADDR_W-1:0] me_addr = '0;
    logic [DATA_W-1:0] me_data = '0;
    bit                m_first = 0;
    bit                last_ga, last_gm;
    int                checks = 0, errors = 0;
    bit                a_pend = 0, m_pend = 0;
    logic [ADDR_W-1:0] prev_w;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit ga, gm, iok;
        @(negedge clk);
        ga = 0; gm = 0;
        if (reset_n) begin
            if (a_valid && m_valid) begin
                ga = !m_first;
                gm = m_first;
            end else begin
                ga = a_valid;
                gm = m_valid;
            end
        end
        iok = reset_n && issue_valid && !busy_m[issue_addr];
        chk("a_ready", a_ready, ga);
        chk("m_ready", m_ready, gm);
        chk("issue_ready", issue_ready, iok);
        chk("r_busy", r_busy, busy_m[R_Addr]);
        chk("s_busy", s_busy, busy_m[S_Addr]);
        chk("rf_read_r", rf_act[R_Addr], rf_m[R_Addr]);
        @(posedge clk);
        if (me_en) rf_m[me_addr] = me_data;
        if (!reset_n) begin
            foreach (busy_m[i]) busy_m[i] = 0;
            me_en = 0; me_addr = '0; me_data = '0; m_first = 0;
        end else begin
            if (me_en) busy_m[me_addr] = 0;
            if (iok) busy_m[issue_addr] = 1;
            if (a_valid && m_valid) m_first = ga;
            me_en = ga || gm;
            if (ga) begin me_addr = a_addr; me_data = a_data; end
            else if (gm) begin me_addr = m_addr; me_data = m_data; end
        end
        last_ga = ga; last_gm = gm;
        #1;
        chk("W_En", W_En, me_en);
        chk("W_Addr", W_Addr, me_addr);
        chk("WR", WR, me_data);
    endtask

    task automatic sweep(input string tag);
        logic [ADDR_W-1:0] keep;
        keep = R_Addr;
        for (int i = 0; i < NREGS; i++) begin
            R_Addr = ADDR_W'(i);
            #1;
            chk(tag, r_busy, busy_m[i]);
        end
        R_Addr = keep;
        #1;
    endtask

    initial begin
        // Test 1: reset with both sources requesting
        a_valid = 1; a_addr = 3; a_data = 64'hAAAA;
        m_valid = 1; m_addr = 4; m_data = 64'h5555;
        @(posedge clk); #1;
        tick(); tick();
        chk("rst_W_En", W_En, 0);
        chk("rst_r_busy", r_busy, 0);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_m_ready", m_ready, 0);
        reset_n = 1; #1;
        chk("rel_a_ready", a_ready, 1);
        tick();
        chk("rel_W_En", W_En, 1);
        chk("rel_W_Addr", W_Addr, 3);
        chk("rel_WR", WR, 64'hAAAA);

        // Test 2: continuous contention alternates 3,4,3,4
        for (int i = 0; i < 3; i++) begin
            prev_w = W_Addr;
            tick();
            chk("cont_W_En", W_En, 1);
            chk("cont_alt", W_Addr, (prev_w == 3) ? 4 : 3);
        end

        // Test 3: lone M requester, then contention goes to A
        a_valid = 0;
        for (int i = 0; i < 3; i++) begin
            m_addr = ADDR_W'(10 + i); m_data = 64'(100 + i);
            #1; chk("single_m_ready", m_ready, 1);
            tick();
            chk("single_W_Addr", W_Addr, 10 + i);
        end
        a_valid = 1;
        tick();
        chk("ptr_a_wins", W_Addr, 3);
        a_valid = 0; m_valid = 0;

        // Test 4: scoreboard RAW around a write to r7
        issue_valid = 1; issue_addr = 7;
        tick();
        R_Addr = 7; #1;
        chk("sb_busy7", r_busy, 1);
        chk("sb_reissue", issue_ready, 0);
        tick();
        issue_valid = 0;
        a_valid = 1; a_addr = 7; a_data = 64'h1234;
        tick();
        a_valid = 0; #1;
        chk("sb_wen_busy", r_busy, 1);
        tick();
        chk("sb_cleared", r_busy, 0);
        chk("sb_rf7", rf_act[7], 64'h1234);

        // Test 5: set and clear on r9 in the same cycle
        a_valid = 1; a_addr = 9; a_data = 64'h9999;
        tick();
        a_valid = 0; issue_valid = 1; issue_addr = 9;
        tick();
        issue_valid = 0; S_Addr = 9; #1;
        chk("setclr_s_busy", s_busy, 1);

        // Test 6: reset mid-operation
        issue_valid = 1; issue_addr = 2;
        tick();
        issue_valid = 0; a_valid = 1; a_addr = 5; a_data = 64'h5A5A;
        tick();
        a_valid = 0; reset_n = 0;
        tick();
        chk("mid_rst_W_En", W_En, 0);
        R_Addr = 2; #1;
        chk("mid_rst_busy2", r_busy, 0);
        sweep("mid_rst_sweep");
        reset_n = 1;

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            reset_n = ($urandom % 80) != 0;
            if (!a_pend && ($urandom % 3 != 0)) begin
                a_pend = 1; a_addr = ADDR_W'($urandom); a_data = {$urandom, $urandom};
            end
            if (!m_pend && ($urandom % 2 != 0)) begin
                m_pend = 1; m_addr = ADDR_W'($urandom); m_data = {$urandom, $urandom};
            end
            a_valid = a_pend; m_valid = m_pend;
            issue_valid = ($urandom % 2) != 0;
            issue_addr = ADDR_W'($urandom_range(0, 7));
            R_Addr = ADDR_W'($urandom_range(0, 7));
            S_Addr = ADDR_W'($urandom);
            tick();
            if (last_ga) a_pend = 0;
            if (last_gm) m_pend = 0;
            if (c % 100 == 99) sweep("rand_sweep");
        end
        reset_n = 1; a_valid = 0; m_valid = 0; issue_valid = 0;
        tick();
        sweep("final_sweep");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
Write-back controller for the 32 x 64-bit register file, which has one write port and two asynchronous read ports. It round-robins the single write port between two write-back sources: A (ALU) and M (memory/load). Each source uses a valid/ready handshake. It also keeps a 32-entry busy scoreboard so issue logic can detect read-after-write and write-after-write hazards on the R and S read addresses. It drives W_En/W_Addr/WR of the register file directly.

Parameters:
DATA_W, 64, write data width
ADDR_W, 5, register address width
NREGS, 32, number of registers (2**ADDR_W)

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  synchronous reset, active low
a_valid  in  1  source A has a write-back
a_addr  in  ADDR_W  source A destination
a_data  in  DATA_W  source A data
a_ready  out  1  source A accepted this cycle
m_valid  in  1  source M has a write-back
m_addr  in  ADDR_W  source M destination
m_data  in  DATA_W  source M data
m_ready  out  1  source M accepted this cycle
issue_valid  in  1  issue stage reserves a destination
issue_addr  in  ADDR_W  destination to reserve
issue_ready  out  1  reservation accepted
R_Addr  in  ADDR_W  read address R (mirrors regfile)
S_Addr  in  ADDR_W  read address S (mirrors regfile)
r_busy  out  1  register at R_Addr has a pending write
s_busy  out  1  register at S_Addr has a pending write
W_En  out  1  regfile write enable
W_Addr  out  ADDR_W  regfile write address
WR  out  DATA_W  regfile write data

Behaviour:
- Clock: single clock clk. Reset is synchronous and active-low on reset_n. All state updates occur on the rising edge of clk.
- Reset (reset_n=0 at a rising edge):
  - W_En=0, W_Addr=0, WR=0.
  - busy[31:0]=0.
  - Priority pointer set to A.
  - a_ready, m_ready and issue_ready are forced 0 while reset_n=0.
  - An in-flight accepted transfer is discarded.
- Arbitration (combinational, same cycle):
  - Only A valid: a_ready=1. Only M valid: m_ready=1.
  - Both valid: the source named by the pointer gets ready=1, the other 0.
  - The pointer moves to the non-granted source only when both were valid and a grant was made. With a single requester the pointer is unchanged.
  - At most one ready per cycle. A transfer occurs when valid&&ready. Sources must hold addr/data stable while valid&&!ready.
- Write stage (registered, latency 1):
  - A transfer in cycle N gives W_En=1 with that addr/data in cycle N+1. The regfile commits at the end of N+1.
  - With no transfer, W_En=0 next cycle; W_Addr and WR hold their last values.
  - Throughput is one write per cycle. There is no backpressure from the regfile.
- Scoreboard:
  - issue_ready = issue_valid && !busy[issue_addr] (combinational).
  - On issue_valid && issue_ready: busy[issue_addr] <= 1.
  - When W_En=1: busy[W_Addr] <= 0.
  - Set and clear on the same address in the same cycle: set wins (bit stays 1).
  - A write to a non-busy address is legal; clearing has no effect.
- Read-hazard outputs:
  - r_busy = busy[R_Addr]; s_busy = busy[S_Addr] (combinational).
  - r_busy and s_busy drop in the cycle after W_En=1 for that address, when the regfile read already returns the new data.
- Widths: all addresses are ADDR_W and index 0..NREGS-1. There is no wrap or overflow state.

Decomposition:
- Package regfile_pkg holds:
  - DATA_W, ADDR_W, NREGS.
  - Source enum {SRC_A, SRC_M} used for the pointer.
- Natural sub-module: rr_arb2 (two-request round-robin arbiter with a pointer register and update on contention). The scoreboard and write stage stay inline.

Test Plan:
1. Reset: hold reset_n=0 for 2 cycles with a_valid=m_valid=1. Require a_ready=m_ready=0, W_En=0, r_busy=0. Release reset: a_ready=1 in that cycle, and W_En=1 with A's addr/data one cycle later.
2. Contention: a_valid=m_valid=1 continuously, a_addr=3/a_data=0xAAAA, m_addr=4/m_data=0x5555. Require W_Addr sequence 3,4,3,4 on consecutive cycles, with W_En=1 every cycle.
3. Single source: only m_valid=1 for 3 cycles. Require m_ready=1 each cycle and 3 writes. Then assert both: A wins first, since the pointer is still A.
4. Scoreboard: issue addr 7, then R_Addr=7 gives r_busy=1. Issue addr 7 again: issue_ready=0. A writes addr 7 with 0x1234. W_En cycle: r_busy still 1. Next cycle: r_busy=0 and regfile R=0x1234.
5. Same-cycle set/clear: W_En=1, W_Addr=9 with issue_valid=1, issue_addr=9 (busy[9]=0 before). Require busy[9]=1 afterwards, and s_busy=1 with S_Addr=9.
6. Reset mid-operation: busy[2]=1 and a transfer accepted in cycle N, reset_n=0 in cycle N+1. Require W_En=0 after reset and busy[2]=0.
